// File: rtl/fetch_queue_pkg.sv
// Shared types and constants for the instruction-fetch queue.
// The fetch entry pairs a returned instruction word with the PC it was fetched from.
package fetch_pkg;

    localparam int PC_W    = 32;
    localparam int INSTR_W = 32;

    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [PC_W-1:0]    pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue_if.sv
// Bus bundle for the fetch queue: instruction-memory request/response channel
// plus the decode-facing instruction handshake.
interface fetch_queue_if
    import fetch_pkg::*;
#(
    parameter int WIDTH = PC_W
);

    logic               imem_req_valid;
    logic [WIDTH-1:0]   imem_req_addr;
    logic               imem_req_ready;
    logic               imem_rsp_valid;
    logic [INSTR_W-1:0] imem_rsp_data;
    logic               instr_valid;
    logic [INSTR_W-1:0] instr;
    logic [WIDTH-1:0]   instr_pc;
    logic               instr_ready;

    modport master (
        output imem_req_valid, imem_req_addr, instr_valid, instr, instr_pc,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data, instr_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr, instr_valid, instr, instr_pc,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data, instr_ready
    );

endinterface

// File: rtl/fetch_queue_chk.sv
// Protocol and overflow assertions for the fetch queue.
module fetch_queue_chk #(
    parameter int CNT_W = 3
) (
    input logic           clk,
    input logic           rst,
    input logic           rsp_valid,
    input logic [CNT_W:0] inflight,
    input logic           tag_push,
    input logic           tag_full,
    input logic           tag_pop,
    input logic           tag_empty,
    input logic           q_push,
    input logic           q_full
);

    a_rsp_needs_inflight: assert property (@(posedge clk) disable iff (!rst)
        !(rsp_valid && (inflight == {(CNT_W+1){1'b0}})));

    a_tag_no_overflow: assert property (@(posedge clk) disable iff (!rst)
        !(tag_push && tag_full));

    a_tag_no_underflow: assert property (@(posedge clk) disable iff (!rst)
        !(tag_pop && tag_empty));

    a_queue_no_overflow: assert property (@(posedge clk) disable iff (!rst)
        !(q_push && q_full));

endmodule

// File: rtl/fetch_queue_sync_fifo.sv
// Single-clock first-word-fall-through FIFO with synchronous clear.
// Push when full and pop when empty are ignored; DEPTH must be a power of two.
module sync_fifo #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   clear,
    input  logic [DATA_W-1:0]      wdata,
    output logic [DATA_W-1:0]      rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    logic [DATA_W-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_r;
    logic [PTR_W-1:0]  rd_ptr_r;
    logic [CNT_W-1:0]  count_r;
    logic              do_push_s;
    logic              do_pop_s;

    // Status flags and qualified push/pop strobes.
    always_comb begin
        full      = (count_r == DEPTH_C);
        empty     = (count_r == {CNT_W{1'b0}});
        do_push_s = push && !full;
        do_pop_s  = pop && !empty;
        rdata     = mem_r[rd_ptr_r];
        count     = count_r;
    end

    // Pointer and occupancy registers; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk) begin
        if (!rst || clear) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (do_push_s) wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            if (do_pop_s)  rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Storage array; contents need no reset since occupancy gates every read.
    always_ff @(posedge clk) begin
        if (rst && !clear && do_push_s) mem_r[wr_ptr_r] <= wdata;
    end

endmodule

// File: rtl/fetch_queue.sv
// Instruction-fetch stage: issues PCC to instruction memory under a credit limit,
// tags requests with their PC and buffers returned words in order for decode.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int WIDTH = PC_W,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] PCC,
    input  logic             flush,
    output logic             pc_advance,
    fetch_queue_if.master    bus
);

    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int ENT_W = INSTR_W + WIDTH;
    localparam logic [CNT_W:0] DEPTH_C = (CNT_W+1)'(DEPTH);

    logic [CNT_W-1:0] tag_count_s;
    logic [CNT_W-1:0] q_count_s;
    logic [CNT_W-1:0] drop_cnt_r;
    logic [CNT_W-1:0] drop_nxt_s;
    logic [CNT_W:0]   inflight_s;
    logic [CNT_W:0]   occupancy_s;
    logic             credit_s;
    logic             req_valid_s;
    logic             req_fire_s;
    logic             rsp_live_s;
    logic             rsp_keep_s;
    logic             q_pop_s;
    logic             tag_full_s;
    logic             tag_empty_s;
    logic             q_full_s;
    logic             q_empty_s;
    logic [WIDTH-1:0] tag_pc_s;
    logic [ENT_W-1:0] q_wdata_s;
    logic [ENT_W-1:0] q_rdata_s;

    // Credit, handshake qualification and drop-count bookkeeping.
    // Stale responses still owed by memory are counted in drop_cnt so credit stays exact across a flush.
    always_comb begin
        inflight_s  = {1'b0, tag_count_s} + {1'b0, drop_cnt_r};
        occupancy_s = inflight_s + {1'b0, q_count_s};
        credit_s    = (occupancy_s < DEPTH_C);
        req_valid_s = rst && !flush && credit_s;
        req_fire_s  = req_valid_s && bus.imem_req_ready;
        rsp_live_s  = bus.imem_rsp_valid && (inflight_s != {(CNT_W+1){1'b0}});
        rsp_keep_s  = rsp_live_s && (drop_cnt_r == {CNT_W{1'b0}}) && !flush;
        q_pop_s     = !q_empty_s && bus.instr_ready && !flush;
        q_wdata_s   = {bus.imem_rsp_data, tag_pc_s};
        if (flush) begin
            drop_nxt_s = drop_cnt_r + tag_count_s - CNT_W'(rsp_live_s);
        end else if (rsp_live_s && (drop_cnt_r != {CNT_W{1'b0}})) begin
            drop_nxt_s = drop_cnt_r - CNT_W'(1);
        end else begin
            drop_nxt_s = drop_cnt_r;
        end
    end

    // Drop counter register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            drop_cnt_r <= {CNT_W{1'b0}};
        end else begin
            drop_cnt_r <= drop_nxt_s;
        end
    end

    // Output drive; an empty queue presents a NOP rather than stale storage.
    always_comb begin
        bus.imem_req_valid = req_valid_s;
        bus.imem_req_addr  = PCC;
        pc_advance         = req_fire_s;
        bus.instr_valid    = !q_empty_s;
        bus.instr_pc       = q_rdata_s[WIDTH-1:0];
        if (q_empty_s) begin
            bus.instr = NOP_INSTR;
        end else begin
            bus.instr = q_rdata_s[ENT_W-1:WIDTH];
        end
    end

    sync_fifo #(
        .DATA_W (WIDTH),
        .DEPTH  (DEPTH)
    ) u_pc_tag (
        .clk   (clk),
        .rst   (rst),
        .push  (req_fire_s),
        .pop   (rsp_keep_s),
        .clear (flush),
        .wdata (PCC),
        .rdata (tag_pc_s),
        .full  (tag_full_s),
        .empty (tag_empty_s),
        .count (tag_count_s)
    );

    sync_fifo #(
        .DATA_W (ENT_W),
        .DEPTH  (DEPTH)
    ) u_instr_q (
        .clk   (clk),
        .rst   (rst),
        .push  (rsp_keep_s),
        .pop   (q_pop_s),
        .clear (flush),
        .wdata (q_wdata_s),
        .rdata (q_rdata_s),
        .full  (q_full_s),
        .empty (q_empty_s),
        .count (q_count_s)
    );

    fetch_queue_chk #(
        .CNT_W (CNT_W)
    ) u_chk (
        .clk       (clk),
        .rst       (rst),
        .rsp_valid (bus.imem_rsp_valid),
        .inflight  (inflight_s),
        .tag_push  (req_fire_s),
        .tag_full  (tag_full_s),
        .tag_pop   (rsp_keep_s),
        .tag_empty (tag_empty_s),
        .q_push    (rsp_keep_s),
        .q_full    (q_full_s)
    );

endmodule

// File: tb/tb_fetch_queue.sv
// Randomized scoreboard bench for fetch_queue with an in-order memory model
// and a PC-register model; decode outputs are checked by a separate monitor.
module tb_fetch_queue;
    import fetch_pkg::*;

    localparam int WIDTH = 32;
    localparam int DEPTH = 4;

    logic        clk   = 1'b0;
    logic        rst   = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] PCC   = 32'd0;
    logic        pc_advance;

    fetch_queue_if #(.WIDTH(WIDTH)) bus ();

    fetch_queue #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .PCC        (PCC),
        .flush      (flush),
        .pc_advance (pc_advance),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    fetch_entry_t exp_q[$];
    logic [31:0]  mem_addr_q[$];
    int           mem_due_q[$];
    int           mem_gen_q[$];

    int cyc = 0, gen = 0, buffered = 0, out_cnt = 0, fire_cnt = 0, last_due = 0;
    int lat = 1, req_rdy_pct = 100, ins_rdy_pct = 100, flush_pct = 0;
    bit lat_rand = 1'b0, toggle_rdy = 1'b0, force_flush = 1'b0;
    bit fire_prev = 1'b0, flush_prev = 1'b0, rst_prev = 1'b0, arm_first = 1'b0;
    logic [31:0] target = 32'd0, force_target = 32'd0, first_pc = 32'hFFFF_FFFF;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a >> 2) ^ 32'hC0DE_0000;
    endfunction

    task automatic check(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: decode-side valid must track the model's buffered count; dequeues pop the scoreboard.
    always @(negedge clk) begin
        check(bus.instr_valid === (buffered > 0), "instr_valid", 64'(bus.instr_valid), 64'(buffered > 0));
        if (rst && !flush && bus.instr_valid && bus.instr_ready) begin
            if (exp_q.size() == 0) begin
                check(1'b0, "unexpected_out", 64'(bus.instr_pc), 64'd0);
            end else begin
                fetch_entry_t e;
                e = exp_q.pop_front();
                check(bus.instr_pc === e.pc, "instr_pc", 64'(bus.instr_pc), 64'(e.pc));
                check(bus.instr === e.instr, "instr", 64'(bus.instr), 64'(e.instr));
                out_cnt++;
                if (arm_first) begin
                    first_pc  = bus.instr_pc;
                    arm_first = 1'b0;
                end
            end
        end
    end

    task automatic step(input bit r);
        bit fire, deq, live, exp_req;
        int due;
        @(posedge clk);
        #1;
        cyc++;
        if (flush_prev)     PCC = target;
        else if (fire_prev) PCC = PCC + 32'd4;
        rst    = r;
        flush  = r && (force_flush || ($urandom_range(99, 0) < flush_pct));
        target = force_flush ? force_target : ($urandom & 32'hFFFF_FFFC);
        bus.imem_req_ready = toggle_rdy ? cyc[0] : ($urandom_range(99, 0) < req_rdy_pct);
        bus.instr_ready    = ($urandom_range(99, 0) < ins_rdy_pct);
        if (r && mem_due_q.size() > 0 && mem_due_q[0] <= cyc) begin
            bus.imem_rsp_valid = 1'b1;
            bus.imem_rsp_data  = mem_word(mem_addr_q[0]);
        end else begin
            bus.imem_rsp_valid = 1'b0;
            bus.imem_rsp_data  = 32'hDEAD_BEEF;
        end
        @(negedge clk);
        #1;
        if (!rst) begin
            check(bus.imem_req_valid === 1'b0, "req_valid_rst", 64'(bus.imem_req_valid), 64'd0);
            check(pc_advance === 1'b0, "pc_advance_rst", 64'(pc_advance), 64'd0);
            if (!rst_prev)
                check(bus.instr_valid === 1'b0, "instr_valid_rst", 64'(bus.instr_valid), 64'd0);
            exp_q.delete(); mem_addr_q.delete(); mem_due_q.delete(); mem_gen_q.delete();
            buffered = 0; last_due = 0; gen++;
            fire_prev = 1'b0; flush_prev = 1'b0;
        end else begin
            exp_req = !flush && (mem_due_q.size() + buffered < DEPTH);
            check(bus.imem_req_valid === exp_req, "req_valid", 64'(bus.imem_req_valid), 64'(exp_req));
            fire = bus.imem_req_valid && bus.imem_req_ready;
            check(pc_advance === fire, "pc_advance", 64'(pc_advance), 64'(fire));
            check(bus.imem_req_addr === PCC, "req_addr", 64'(bus.imem_req_addr), 64'(PCC));
            deq = bus.instr_valid && bus.instr_ready && !flush;
            if (bus.imem_rsp_valid) begin
                live = (mem_gen_q[0] == gen) && !flush;
                void'(mem_addr_q.pop_front()); void'(mem_due_q.pop_front()); void'(mem_gen_q.pop_front());
                if (live) buffered++;
            end
            if (deq) buffered--;
            if (fire) begin
                fire_cnt++;
                exp_q.push_back('{instr: mem_word(PCC), pc: PCC});
                due = cyc + (lat_rand ? int'($urandom_range(4, 1)) : lat);
                if (due <= last_due) due = last_due + 1;
                last_due = due;
                mem_addr_q.push_back(PCC); mem_due_q.push_back(due); mem_gen_q.push_back(gen);
            end
            if (flush) begin
                exp_q.delete();
                buffered  = 0;
                gen++;
                arm_first = 1'b1;
            end
            fire_prev  = fire;
            flush_prev = flush;
        end
        rst_prev = rst;
    endtask

    logic [31:0] restart_pc;

    initial begin
        bus.imem_req_ready = 1'b0;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = 32'd0;
        bus.instr_ready    = 1'b0;

        // Reset, then stream from PC 0 with single-cycle memory.
        step(1'b0); step(1'b0);
        out_cnt = 0;
        repeat (20) step(1'b1);
        check(out_cnt == 18, "throughput", 64'(out_cnt), 64'd18);

        // Decode stalled: credit caps outstanding fetches at DEPTH.
        step(1'b0);
        ins_rdy_pct = 0; fire_cnt = 0;
        repeat (10) step(1'b1);
        check(fire_cnt == DEPTH, "stall_fires", 64'(fire_cnt), 64'(DEPTH));
        ins_rdy_pct = 100;
        repeat (12) step(1'b1);

        // Flush with two slow fetches still in flight.
        step(1'b0);
        lat = 3;
        step(1'b1); step(1'b1);
        force_flush = 1'b1; force_target = 32'h0000_0100; first_pc = 32'hFFFF_FFFF;
        step(1'b1);
        force_flush = 1'b0;
        repeat (12) step(1'b1);
        check(first_pc == 32'h100, "flush_target", 64'(first_pc), 64'h100);

        // Flush in the same cycle a response lands.
        lat = 1;
        repeat (6) step(1'b1);
        force_flush = 1'b1; force_target = 32'h0000_0200; first_pc = 32'hFFFF_FFFF;
        step(1'b1);
        force_flush = 1'b0;
        repeat (8) step(1'b1);
        check(first_pc == 32'h200, "flush_rsp_target", 64'(first_pc), 64'h200);

        // Alternating request-ready.
        toggle_rdy = 1'b1;
        repeat (16) step(1'b1);
        toggle_rdy = 1'b0;

        // Random traffic with variable latency, backpressure and flushes.
        lat_rand = 1'b1; req_rdy_pct = 70; ins_rdy_pct = 70; flush_pct = 5;
        repeat (400) step(1'b1);
        lat_rand = 1'b0; req_rdy_pct = 100; ins_rdy_pct = 100; flush_pct = 0; lat = 1;

        // Reset mid-stream with two entries queued.
        step(1'b0);
        ins_rdy_pct = 0;
        repeat (3) step(1'b1);
        step(1'b0); step(1'b0);
        ins_rdy_pct = 100; first_pc = 32'hFFFF_FFFF; arm_first = 1'b1;
        restart_pc = PCC;
        repeat (8) step(1'b1);
        check(first_pc == restart_pc, "restart_pc", 64'(first_pc), 64'(restart_pc));

        // Drain: stop requesting and let every accepted fetch reach decode.
        req_rdy_pct = 0;
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) step(1'b1);
        check(exp_q.size() == 0, "drain", 64'(exp_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
